// File: rtl/fuel_gauge_ctrl_pkg.sv
// Purpose: shared types and constants for the fuel gauge: FSM state enum, sprite frame codes, level thresholds.
// Latency: none; this file holds types, constants and one pure function.
// Backpressure: none.
package fuel_gauge_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_EMPTY  = 2'd1,
    ST_REFILL = 2'd2
  } fuel_state_e;

  typedef logic [1:0] frame_sel_t;

  localparam frame_sel_t FRAME_FULL = 2'd0;
  localparam frame_sel_t FRAME_3Q   = 2'd1;
  localparam frame_sel_t FRAME_HALF = 2'd2;
  localparam frame_sel_t FRAME_LOW  = 2'd3;

  localparam logic [7:0] LVL_3Q   = 8'd192;
  localparam logic [7:0] LVL_HALF = 8'd128;
  localparam logic [7:0] LVL_LOW  = 8'd64;

  localparam logic [7:0] FUEL_MAX = 8'd255;
  localparam logic [5:0] PEND_MAX = 6'd63;

  function automatic frame_sel_t level_to_frame(input logic [7:0] lvl);
    if (lvl >= LVL_3Q)   return FRAME_FULL;
    if (lvl >= LVL_HALF) return FRAME_3Q;
    if (lvl >= LVL_LOW)  return FRAME_HALF;
    return FRAME_LOW;
  endfunction

endpackage

// File: rtl/fuel_gauge_ctrl_if.sv
// Purpose: bundles the gauge's raster inputs, fuel events and sprite/status outputs.
// Latency: none; this interface holds wires only.
// Backpressure: none. master = video timing / game logic side, slave = fuel_gauge_ctrl.
interface fuel_gauge_ctrl_if;
  import fuel_gauge_ctrl_pkg::*;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       consume;
  logic       refill;
  logic [9:0] rom_address;
  frame_sel_t frame_sel;
  logic       pixel_valid;
  logic [7:0] fuel_level;
  logic       fuel_empty;
  logic       refilling;

  modport master (
    output DrawX, DrawY, blank, consume, refill,
    input  rom_address, frame_sel, pixel_valid, fuel_level, fuel_empty, refilling
  );

  modport slave (
    input  DrawX, DrawY, blank, consume, refill,
    output rom_address, frame_sel, pixel_valid, fuel_level, fuel_empty, refilling
  );
endinterface

// File: rtl/fuel_gauge_ctrl_sprite_addr_gen.sv
// Purpose: gauge window detect and counter-based sprite ROM address generation.
// Latency: rom_address is combinational from the current pixel; pixel_valid is 1 cycle later to match ROM q.
// Backpressure: none; follows the raster. Ports: vga_clk, reset_n, draw_x/draw_y/blank in, rom_address/pixel_valid out.
module sprite_addr_gen
  import fuel_gauge_ctrl_pkg::*;
#(
  parameter logic [9:0] GAUGE_X = 10'd560,
  parameter logic [9:0] GAUGE_Y = 10'd16,
  parameter int         SPR_W   = 44,
  parameter int         SPR_H   = 22,
  parameter int         SCALE   = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic       blank,
  output logic [9:0] rom_address,
  output logic       pixel_valid
);

  localparam logic [10:0] X_END    = 11'(GAUGE_X) + 11'(SPR_W * SCALE);
  localparam logic [10:0] Y_END    = 11'(GAUGE_Y) + 11'(SPR_H * SCALE);
  localparam logic [1:0]  SUB_LAST = 2'(SCALE - 1);
  localparam logic [9:0]  ROW_STEP = 10'(SPR_W);

  logic [9:0] tex_col_q, tex_col_d;
  logic [1:0] sub_x_q, sub_x_d;
  logic [1:0] sub_y_q, sub_y_d;
  logic [9:0] row_base_q, row_base_d;
  logic       synced_q, synced_d;
  logic       pixel_valid_q, pixel_valid_d;

  logic       x_in, y_in, win_ok;
  logic       col_clr, row_clr, row_adv;
  logic [9:0] col_cur;
  logic [1:0] sub_x_cur;

  always_comb begin
    x_in    = ({1'b0, draw_x} >= {1'b0, GAUGE_X}) && ({1'b0, draw_x} < X_END);
    y_in    = ({1'b0, draw_y} >= {1'b0, GAUGE_Y}) && ({1'b0, draw_y} < Y_END);
    col_clr = (draw_x == GAUGE_X);
    row_clr = (draw_y == GAUGE_Y) && (draw_x == 10'd0);
    row_adv = (draw_x == 10'd0) && y_in && !row_clr;

    // Clears act on the pixel they occur on, so the "current" values feed
    // the address in the same cycle and the _d values are what follows.
    col_cur   = col_clr ? 10'd0 : tex_col_q;
    sub_x_cur = col_clr ? 2'd0  : sub_x_q;
    tex_col_d = col_cur;
    sub_x_d   = sub_x_cur;
    if (x_in) begin
      if (sub_x_cur == SUB_LAST) begin
        sub_x_d   = 2'd0;
        tex_col_d = col_cur + 10'd1;
      end else begin
        sub_x_d = sub_x_cur + 2'd1;
      end
    end

    // Row state changes only at column 0, so the _d value is valid for the
    // whole screen row and is used directly as the current row_base.
    sub_y_d    = sub_y_q;
    row_base_d = row_base_q;
    if (row_clr) begin
      sub_y_d    = 2'd0;
      row_base_d = 10'd0;
    end else if (row_adv) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y_d    = 2'd0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        sub_y_d = sub_y_q + 2'd1;
      end
    end

    // After reset the counters are meaningless until the first row clear.
    synced_d      = synced_q | row_clr;
    win_ok        = x_in && y_in && synced_d;
    rom_address   = win_ok ? (row_base_d + col_cur) : 10'd0;
    pixel_valid_d = blank && win_ok;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tex_col_q     <= 10'd0;
      sub_x_q       <= 2'd0;
      sub_y_q       <= 2'd0;
      row_base_q    <= 10'd0;
      synced_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      tex_col_q     <= tex_col_d;
      sub_x_q       <= sub_x_d;
      sub_y_q       <= sub_y_d;
      row_base_q    <= row_base_d;
      synced_q      <= synced_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign pixel_valid = pixel_valid_q;

endmodule

// File: rtl/fuel_gauge_ctrl.sv
// Purpose: fuel level FSM (NORMAL/EMPTY/REFILL) updated once per frame, plus sprite addressing for the gauge.
// Latency: fuel outputs change one cycle after the frame boundary pixel; pixel_valid 1 cycle after the pixel.
// Backpressure: none; consume/refill are single-cycle pulses. Ports: vga_clk, reset_n, bus (slave modport).
module fuel_gauge_ctrl
  import fuel_gauge_ctrl_pkg::*;
#(
  parameter logic [9:0] GAUGE_X      = 10'd560,
  parameter logic [9:0] GAUGE_Y      = 10'd16,
  parameter int         SPR_W        = 44,
  parameter int         SPR_H        = 22,
  parameter int         SCALE        = 2,
  parameter logic [7:0] CONSUME_STEP = 8'd4,
  parameter logic [7:0] REFILL_STEP  = 8'd8
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  fuel_gauge_ctrl_if.slave   bus
);

  fuel_state_e state_q, state_d;
  logic [7:0]  fuel_q, fuel_d;
  frame_sel_t  frame_sel_q, frame_sel_d;
  logic [5:0]  pend_q, pend_d;
  logic        refill_req_q, refill_req_d;
  logic        fuel_empty_q, fuel_empty_d;
  logic        refilling_q, refilling_d;

  logic        boundary;
  logic        req_acc;
  logic [5:0]  pend_acc;
  logic [13:0] drain;
  logic [8:0]  topped;

  sprite_addr_gen #(
    .GAUGE_X (GAUGE_X),
    .GAUGE_Y (GAUGE_Y),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .SCALE   (SCALE)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .draw_x      (bus.DrawX),
    .draw_y      (bus.DrawY),
    .blank       (bus.blank),
    .rom_address (bus.rom_address),
    .pixel_valid (bus.pixel_valid)
  );

  always_comb begin
    boundary = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

    // Pulses on the boundary cycle itself count toward that boundary.
    // A refill in the same cycle swallows the consume; pend_q is always 0
    // outside NORMAL, so gating on state keeps it there.
    req_acc  = refill_req_q | bus.refill;
    pend_acc = pend_q;
    if ((state_q == ST_NORMAL) && bus.consume && !bus.refill && (pend_q != PEND_MAX)) begin
      pend_acc = pend_q + 6'd1;
    end

    drain  = 14'(pend_acc) * 14'(CONSUME_STEP);
    topped = {1'b0, fuel_q} + {1'b0, REFILL_STEP};

    state_d      = state_q;
    fuel_d       = fuel_q;
    frame_sel_d  = frame_sel_q;
    pend_d       = pend_acc;
    refill_req_d = req_acc;
    fuel_empty_d = fuel_empty_q;
    refilling_d  = refilling_q;

    if (boundary) begin
      pend_d       = 6'd0;
      refill_req_d = 1'b0;
      // A pending refill request always wins and leaves the level untouched
      // on the boundary where REFILL is entered.
      if (req_acc) begin
        state_d = ST_REFILL;
      end else begin
        case (state_q)
          ST_NORMAL: begin
            if (drain >= {6'd0, fuel_q}) begin
              fuel_d  = 8'd0;
              state_d = ST_EMPTY;
            end else begin
              fuel_d = fuel_q - drain[7:0];
            end
          end
          ST_REFILL: begin
            if (topped >= {1'b0, FUEL_MAX}) begin
              fuel_d  = FUEL_MAX;
              state_d = ST_NORMAL;
            end else begin
              fuel_d = topped[7:0];
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      frame_sel_d  = level_to_frame(fuel_d);
      fuel_empty_d = (state_d == ST_EMPTY);
      refilling_d  = (state_d == ST_REFILL);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_NORMAL;
      fuel_q       <= FUEL_MAX;
      frame_sel_q  <= FRAME_FULL;
      pend_q       <= 6'd0;
      refill_req_q <= 1'b0;
      fuel_empty_q <= 1'b0;
      refilling_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fuel_q       <= fuel_d;
      frame_sel_q  <= frame_sel_d;
      pend_q       <= pend_d;
      refill_req_q <= refill_req_d;
      fuel_empty_q <= fuel_empty_d;
      refilling_q  <= refilling_d;
    end
  end

  assign bus.fuel_level = fuel_q;
  assign bus.frame_sel  = frame_sel_q;
  assign bus.fuel_empty = fuel_empty_q;
  assign bus.refilling  = refilling_q;

endmodule

// File: tb/tb_fuel_gauge_ctrl.sv
// Purpose: self-checking bench for fuel_gauge_ctrl: window scan, per-frame fuel table, random pulses, mid-window reset.
// Latency: expects rom_address in the pixel's own cycle and pixel_valid/fuel outputs one cycle after.
// Backpressure: none; stimulus is driven one pixel per clock.
module tb_fuel_gauge_ctrl;

  localparam int GX_I = 560;
  localparam int GY_I = 16;
  localparam int W    = 44;
  localparam int H    = 22;
  localparam int S    = 2;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  fuel_gauge_ctrl_if bus ();

  fuel_gauge_ctrl #(
    .GAUGE_X      (10'(GX_I)),
    .GAUGE_Y      (10'(GY_I)),
    .SPR_W        (W),
    .SPR_H        (H),
    .SCALE        (S),
    .CONSUME_STEP (8'd4),
    .REFILL_STEP  (8'd8)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: level as a plain integer, mode 0 normal / 1 empty / 2 refill.
  int         m_level;
  int         m_mode;
  int         m_pend;
  bit         m_req;
  bit         m_synced;
  logic [9:0] last_addr;

  typedef struct {
    int n_consume;
    int rmode;      // 0 none, 1 refill alone, 2 refill together with last consume
    int level;
    int sel;
    bit empty;
    bit refilling;
  } frame_vec_t;

  frame_vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= GX_I) && (x < GX_I + W * S) && (y >= GY_I) && (y < GY_I + H * S);
  endfunction

  function automatic int frame_of(input int lvl);
    if (lvl >= 192) return 0;
    if (lvl >= 128) return 1;
    if (lvl >= 64)  return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_level  = 255;
    m_mode   = 0;
    m_pend   = 0;
    m_req    = 1'b0;
    m_synced = 1'b0;
  endtask

  task automatic model_step(input int x, input int y, input bit b, input bit c, input bit r,
                            output bit pv);
    if (x == 0 && y == GY_I) m_synced = 1'b1;
    pv = b && in_win(x, y) && m_synced;
    if (r) m_req = 1'b1;
    else if (c && m_mode == 0 && m_pend < 63) m_pend++;
    if (x == 0 && y == 0) begin
      if (m_req) begin
        m_mode = 2;
      end else if (m_mode == 0) begin
        m_level = m_level - m_pend * 4;
        if (m_level <= 0) begin
          m_level = 0;
          m_mode  = 1;
        end
      end else if (m_mode == 2) begin
        m_level = m_level + 8;
        if (m_level >= 255) begin
          m_level = 255;
          m_mode  = 0;
        end
      end
      m_pend = 0;
      m_req  = 1'b0;
    end
  endtask

  task automatic tick(input int x, input int y, input bit b, input bit c, input bit r,
                      input bit chk_addr);
    bit pv;
    int ea;
    @(negedge vga_clk);
    bus.DrawX   = 10'(x);
    bus.DrawY   = 10'(y);
    bus.blank   = b;
    bus.consume = c;
    bus.refill  = r;
    #1;
    ea = (in_win(x, y) && (m_synced || (x == 0 && y == GY_I)))
         ? ((y - GY_I) / S) * W + (x - GX_I) / S : 0;
    last_addr = bus.rom_address;
    if (chk_addr) check("rom_address", 32'(bus.rom_address), ea);
    @(posedge vga_clk);
    #1;
    model_step(x, y, b, c, r, pv);
    check("pixel_valid", 32'(bus.pixel_valid), 32'(pv));
    check("fuel_level", 32'(bus.fuel_level), m_level);
    check("frame_sel", 32'(bus.frame_sel), frame_of(m_level));
    check("fuel_empty", 32'(bus.fuel_empty), 32'(m_mode == 1));
    check("refilling", 32'(bus.refilling), 32'(m_mode == 2));
  endtask

  task automatic scan_rows(input int y_first, input int y_last, input bit spots);
    for (int y = y_first; y <= y_last; y++) begin
      tick(0, y, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int x = GX_I - 2; x < GX_I + W * S + 2; x++) begin
        tick(x, y, 1'b1, 1'b0, 1'b0, 1'b1);
        if (spots && x == GX_I && y == GY_I) begin
          check("first_texel_addr", 32'(last_addr), 0);
          check("first_texel_valid", 32'(bus.pixel_valid), 1);
        end
        if (spots && x == GX_I + 3 && y == GY_I + 2) begin
          check("texel_45_addr", 32'(last_addr), 45);
          check("texel_45_valid", 32'(bus.pixel_valid), 1);
        end
        if (spots && x == GX_I + W * S - 1 && y == GY_I + H * S - 1) begin
          check("last_texel_addr", 32'(last_addr), 967);
          check("last_texel_valid", 32'(bus.pixel_valid), 1);
        end
      end
    end
  endtask

  task automatic apply_frame(input int n, input int rmode);
    for (int i = 0; i < n; i++) begin
      tick(700, 100, 1'b1, 1'b1, (rmode == 2) && (i == n - 1), 1'b0);
      tick(700, 100, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    if (rmode == 1) tick(700, 100, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int lvl, input int sel, input bit empty,
                             input bit refl);
    check({tag, "_level"}, 32'(bus.fuel_level), lvl);
    check({tag, "_sel"}, 32'(bus.frame_sel), sel);
    check({tag, "_empty"}, 32'(bus.fuel_empty), 32'(empty));
    check({tag, "_refilling"}, 32'(bus.refilling), 32'(refl));
  endtask

  initial begin
    tbl[0] = '{10, 0, 215, 0, 1'b0, 1'b0};
    tbl[1] = '{40, 0,  55, 3, 1'b0, 1'b0};
    tbl[2] = '{12, 0,   7, 3, 1'b0, 1'b0};
    tbl[3] = '{ 5, 0,   0, 3, 1'b1, 1'b0};
    tbl[4] = '{ 6, 0,   0, 3, 1'b1, 1'b0};
    tbl[5] = '{ 0, 1,   0, 3, 1'b0, 1'b1};
    tbl[6] = '{ 4, 0,   8, 3, 1'b0, 1'b1};
    tbl[7] = '{39, 0,  99, 2, 1'b0, 1'b0};
    tbl[8] = '{ 1, 2,  99, 2, 1'b0, 1'b1};

    bus.DrawX   = 10'd799;
    bus.DrawY   = 10'd524;
    bus.blank   = 1'b0;
    bus.consume = 1'b0;
    bus.refill  = 1'b0;
    model_reset();

    #23;
    check("reset_rom_address", 32'(bus.rom_address), 0);
    check("reset_pixel_valid", 32'(bus.pixel_valid), 0);
    check_frame("reset", 255, 0, 1'b0, 1'b0);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Full window raster with spot addresses.
    scan_rows(GY_I, GY_I + H * S - 1, 1'b1);

    // Per-frame fuel table, with the 32-frame refill run in the middle.
    for (int i = 0; i <= 6; i++) begin
      apply_frame(tbl[i].n_consume, tbl[i].rmode);
      check_frame($sformatf("tbl%0d", i), tbl[i].level, tbl[i].sel, tbl[i].empty, tbl[i].refilling);
    end
    for (int k = 1; k <= 31; k++) begin
      int lvl;
      apply_frame(0, 0);
      lvl = (8 + 8 * k > 255) ? 255 : 8 + 8 * k;
      check_frame($sformatf("refill%0d", k), lvl, frame_of(lvl), 1'b0, k < 31);
    end
    for (int i = 7; i <= 8; i++) begin
      apply_frame(tbl[i].n_consume, tbl[i].rmode);
      check_frame($sformatf("tbl%0d", i), tbl[i].level, tbl[i].sel, tbl[i].empty, tbl[i].refilling);
    end

    // Random pulses and positions against the model (address counters not
    // meaningful here since the raster is scrambled).
    for (int f = 0; f < 120; f++) begin
      int n;
      n = int'($urandom_range(25, 5));
      for (int k = 0; k < n; k++) begin
        tick(int'($urandom_range(700, 500)), int'($urandom_range(100, 0)),
             $urandom_range(1, 0) != 0, $urandom_range(2, 0) == 0,
             $urandom_range(40, 0) == 0, 1'b0);
      end
      tick(0, 0, $urandom_range(1, 0) != 0, $urandom_range(1, 0) != 0,
           $urandom_range(10, 0) == 0, 1'b0);
    end

    // Reset in the middle of the window.
    tick(0, GY_I, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int x = GX_I - 1; x <= GX_I + 10; x++) tick(x, GY_I, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge vga_clk);
    bus.DrawX   = 10'(GX_I + 11);
    bus.DrawY   = 10'(GY_I);
    bus.blank   = 1'b1;
    bus.consume = 1'b0;
    bus.refill  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rom_address", 32'(bus.rom_address), 0);
    check("midrst_pixel_valid", 32'(bus.pixel_valid), 0);
    check_frame("midrst", 255, 0, 1'b0, 1'b0);
    model_reset();
    @(posedge vga_clk);
    #3 reset_n = 1'b1;
    for (int x = GX_I + 12; x < GX_I + W * S + 2; x++) tick(x, GY_I, 1'b1, 1'b0, 1'b0, 1'b1);
    scan_rows(GY_I + 1, GY_I + 3, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    scan_rows(GY_I, GY_I + 3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fuel_gauge_ctrl.md
FUEL_GAUGE_CTRL -- requirements
Module: fuel_gauge_ctrl

Interface
REQ-001 Parameters (name, default, meaning): GAUGE_X, 10'd560, left pixel column of gauge window; GAUGE_Y, 10'd16, top pixel row; SPR_W, 44, sprite width in texels; SPR_H, 22, sprite height in texels; SCALE, 2, screen pixels per texel (power of two, 1..4); CONSUME_STEP, 8'd4, fuel units removed per consume pulse; REFILL_STEP, 8'd8, fuel units added per frame while refilling.
REQ-002 Ports: vga_clk in 1, sole clock; reset_n in 1, asynchronous active-low reset.
REQ-003 DrawX in 10, current pixel column; DrawY in 10, current pixel row; blank in 1, 1 = active video.
REQ-004 consume in 1, single-cycle fuel-use pulse; refill in 1, single-cycle refill request pulse.
REQ-005 rom_address out 10, texel index into sprite ROM; frame_sel out 2, sprite frame (0 full, 1 three-quarter, 2 half, 3 low/empty).
REQ-006 pixel_valid out 1, gauge pixel present, aligned to 1-cycle ROM latency; fuel_level out 8; fuel_empty out 1; refilling out 1.

Function
REQ-007 Window: in_window SHALL be 1 when GAUGE_X <= DrawX < GAUGE_X+SPR_W*SCALE and GAUGE_Y <= DrawY < GAUGE_Y+SPR_H*SCALE.
REQ-008 Address generation SHALL use counters only, no multipliers or dividers: texel column, texel row, sub-pixel X/Y counters (0..SCALE-1), and row_base register.
REQ-009 rom_address SHALL equal row_base + texel column, where row_base = texel row * SPR_W, advanced by adding SPR_W once every SCALE screen rows.
REQ-010 Column and sub-pixel X counters SHALL clear when DrawX == GAUGE_X; row counters and row_base SHALL clear when DrawY == GAUGE_Y and DrawX == 0.
REQ-011 Outside the window rom_address SHALL hold 0.
REQ-012 pixel_valid SHALL be blank & in_window registered once, matching ROM q timing.
REQ-013 Frame boundary SHALL be the cycle with DrawX == 0 and DrawY == 0; fuel_level, state and frame_sel SHALL update only there.
REQ-014 consume pulses between boundaries SHALL accumulate in a 6-bit pending counter saturating at 63.
REQ-015 State machine states: NORMAL, EMPTY, REFILL.
REQ-016 NORMAL at boundary: fuel_level -= pending*CONSUME_STEP, saturating at 0; if result 0 -> EMPTY.
REQ-017 EMPTY: consume pulses ignored, pending held 0; fuel_empty = 1.
REQ-018 refill pulse in any state SHALL set a refill-request flag; at boundary flag -> REFILL, flag and pending cleared.
REQ-019 REFILL at boundary: fuel_level += REFILL_STEP, saturating at 255; on reaching 255 -> NORMAL; consume pulses ignored; refilling = 1.
REQ-020 refill and consume in same cycle: refill wins, that consume discarded.
REQ-021 frame_sel latched at boundary from updated level: >=192 -> 0, >=128 -> 1, >=64 -> 2, else 3.
REQ-022 fuel_empty = (state == EMPTY); refilling = (state == REFILL); both registered.

Reset
REQ-023 reset_n low SHALL asynchronously set: fuel_level 255, state NORMAL, frame_sel 0, pending 0, refill flag 0, rom_address 0, pixel_valid 0, fuel_empty 0, refilling 0, all address counters 0.
REQ-024 Reset release mid-frame SHALL produce no pixel_valid until window counters resynchronise at the next GAUGE_X/GAUGE_Y clear events.

Structure
REQ-025 Shared package SHALL hold the fuel state enum, frame_sel encodings and threshold constants (192/128/64).
REQ-026 One sub-module, sprite_addr_gen, SHALL contain REQ-007..REQ-012; the fuel FSM stays in the top.

Verification
REQ-027 Reset, then full frame with SCALE=2: pixel (GAUGE_X, GAUGE_Y) -> rom_address 0; (GAUGE_X+3, GAUGE_Y+2) -> 45; last window pixel -> 967; pixel_valid one cycle after each.
REQ-028 10 consume pulses in one frame from 255 -> fuel_level 215 at next boundary, frame_sel 0; 40 more pulses -> 55, frame_sel 3.
REQ-029 Level 8, 5 pulses -> fuel_level 0, fuel_empty 1; further pulses -> level stays 0.
REQ-030 refill in EMPTY -> REFILL at next boundary, +8 per frame, saturates 255 after 32 frames, state NORMAL, refilling 0.
REQ-031 consume and refill same cycle at level 100 -> no decrement, REFILL entered.
REQ-032 reset_n asserted mid-window -> outputs zero immediately; after release, pixel_valid only from next full window.
